// File: rtl/dct_serial_rx_if.sv
// Serial sample input, block framing controls and parallel sample handshake toward the DCT core.
// master drives the stream and ready (upstream source plus core side); slave is the receiver.
interface dct_serial_rx_if #(parameter int DATA_W = 16);
   logic              valid;
   logic [2:0]        size;
   logic              sval;
   logic              sdat;
   logic [DATA_W-1:0] data;
   logic [4:0]        idx;
   logic              last;
   logic              dvalid;
   logic              dready;
   logic              busy;
   logic [2:0]        err;

   modport master (output valid, size, sval, sdat, dready,
                   input  data, idx, last, dvalid, busy, err);
   modport slave  (input  valid, size, sval, sdat, dready,
                   output data, idx, last, dvalid, busy, err);
endinterface

// File: rtl/dct_serial_rx.sv
// Bit-serial to parallel sample deserialiser that frames 4/8/16/32-point blocks for the DCT32 core.
module dct_serial_rx #(
   parameter int DATA_W = 16
) (
   input logic             clk,
   input logic             rst_n,
   dct_serial_rx_if.slave  bus
);
   localparam int BW = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

   state_t            state, state_nx;
   logic [DATA_W-1:0] shreg;
   logic [BW-1:0]     bitcnt;
   logic [4:0]        n_m1;
   logic [4:0]        wcnt;
   logic              size_ok, xfer, word_done, load;

   always_comb begin
      size_ok   = (bus.size < 3'd4);
      xfer      = bus.dvalid & bus.dready;
      word_done = (state == RECV) & bus.sval & (bitcnt == BW'(DATA_W-1));
      // a completing word may replace the output slot in the same cycle it is taken
      load      = word_done & (~bus.dvalid | bus.dready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.valid && size_ok)  state_nx = RECV;
         RECV:    if (load && wcnt == n_m1)  state_nx = DRAIN;
         DRAIN:   if (xfer && bus.last)      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg      <= '0;
         bitcnt     <= '0;
         n_m1       <= '0;
         wcnt       <= '0;
         bus.data   <= '0;
         bus.idx    <= '0;
         bus.last   <= 1'b0;
         bus.dvalid <= 1'b0;
         bus.err    <= '0;
      end else begin
         if (state == IDLE && bus.valid) begin
            if (size_ok) begin
               n_m1    <= 5'((6'd4 << bus.size) - 6'd1);
               wcnt    <= '0;
               bitcnt  <= '0;
               bus.err <= '0;
            end else begin
               bus.err[2] <= 1'b1;
            end
         end

         if (state == RECV) begin
            if (bus.sval) begin
               shreg  <= {shreg[DATA_W-2:0], bus.sdat};
               bitcnt <= word_done ? '0 : bitcnt + BW'(1);
            end else if (bitcnt != '0) begin
               // mid-word gap: throw the partial word away, index stays put
               bus.err[0] <= 1'b1;
               bitcnt     <= '0;
            end
            if (word_done && !load) bus.err[1] <= 1'b1;
         end

         if (load) begin
            bus.data   <= {shreg[DATA_W-2:0], bus.sdat};
            bus.idx    <= wcnt;
            bus.last   <= (wcnt == n_m1);
            wcnt       <= wcnt + 5'd1;
            bus.dvalid <= 1'b1;
         end else if (xfer) begin
            bus.dvalid <= 1'b0;
         end
      end
   end

   assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_dct_serial_rx.sv
// Self-checking bench for dct_serial_rx: size table, randomized blocks against a queue model, corner sequences.
module tb_dct_serial_rx;
   localparam int DATA_W = 16;

   typedef struct { logic [15:0] d; logic [4:0] i; logic l; } smp_t;
   typedef struct { logic [2:0] size; logic [2:0] exp_err; logic exp_busy; int n; } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   smp_t got[$];

   dct_serial_rx_if #(.DATA_W(DATA_W)) bus();
   dct_serial_rx #(.DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // transfer capture plus stability of a stalled output
   logic        stall_q = 1'b0;
   logic [22:0] held_q  = '0;
   always @(negedge clk) begin
      if (rst_n && stall_q)
         chk("hold", {9'd0, bus.dvalid, bus.data, bus.idx, bus.last}, {9'd0, held_q});
      if (rst_n && bus.dvalid && bus.dready)
         got.push_back('{bus.data, bus.idx, bus.last});
      stall_q <= rst_n && bus.dvalid && !bus.dready;
      held_q  <= {bus.dvalid, bus.data, bus.idx, bus.last};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [15:0] w, input int hi, input int lo);
      for (int b = hi; b >= lo; b--) begin
         bus.sval = 1'b1;
         bus.sdat = w[b];
         tick();
      end
      bus.sval = 1'b0;
   endtask

   task automatic arm(input logic [2:0] s);
      bus.valid = 1'b1;
      bus.size  = s;
      tick();
      bus.valid = 1'b0;
   endtask

   // model: every complete word in order gets index k, last on k==n-1; any truncation sets framing
   task automatic run_block(input int n, input bit gaps, input bit trunc);
      logic [15:0] w;
      smp_t        exp[$];
      bit          ferr = 1'b0;
      got.delete();
      for (int k = 0; k < n; k++) begin
         if (gaps) begin
            if (trunc && $urandom_range(0, 3) == 0) begin
               int nb = $urandom_range(1, 15);
               w = 16'($urandom);
               send_bits(w, 15, 16 - nb);
               tick();
               ferr = 1'b1;
            end
            repeat ($urandom_range(0, 3)) begin
               if ($urandom_range(0, 4) == 0) begin
                  bus.valid = 1'b1;
                  bus.size  = 3'($urandom);
               end
               tick();
               bus.valid = 1'b0;
            end
         end
         w = 16'($urandom);
         send_bits(w, 15, 0);
         exp.push_back('{w, 5'(k), (k == n - 1)});
      end
      tick();
      tick();
      chk("blk_busy", {31'd0, bus.busy}, 32'd0);
      chk("blk_err", {29'd0, bus.err}, {31'd0, ferr});
      chk("blk_cnt", got.size(), exp.size());
      for (int k = 0; k < exp.size() && k < got.size(); k++) begin
         chk("blk_data", {16'd0, got[k].d}, {16'd0, exp[k].d});
         chk("blk_idx",  {27'd0, got[k].i}, {27'd0, exp[k].i});
         chk("blk_last", {31'd0, got[k].l}, {31'd0, exp[k].l});
      end
   endtask

   initial begin
      vec_t        tbl[8];
      logic [15:0] t1[4];
      int          s;

      tbl[0] = '{3'd5, 3'b100, 1'b0, 0};
      tbl[1] = '{3'd1, 3'b000, 1'b1, 8};
      tbl[2] = '{3'd7, 3'b100, 1'b0, 0};
      tbl[3] = '{3'd0, 3'b000, 1'b1, 4};
      tbl[4] = '{3'd4, 3'b100, 1'b0, 0};
      tbl[5] = '{3'd2, 3'b000, 1'b1, 16};
      tbl[6] = '{3'd6, 3'b100, 1'b0, 0};
      tbl[7] = '{3'd3, 3'b000, 1'b1, 32};
      t1[0] = 16'h8001; t1[1] = 16'h7FFF; t1[2] = 16'h0000; t1[3] = 16'h1234;

      bus.valid = 1'b0; bus.size = 3'd0; bus.sval = 1'b0; bus.sdat = 1'b0; bus.dready = 1'b1;
      #12;
      chk("rst_out", {5'd0, bus.data, bus.idx, bus.last, bus.dvalid, bus.busy, bus.err}, 32'd0);
      rst_n = 1'b1;
      tick();

      // back-to-back 4-point block, latency checked bit by bit
      arm(3'd0);
      chk("t1_busy", {31'd0, bus.busy}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         send_bits(t1[k], 15, 1);
         chk("t1_pre_dv", {31'd0, bus.dvalid}, 32'd0);
         send_bits(t1[k], 0, 0);
         chk("t1_dv",   {31'd0, bus.dvalid}, 32'd1);
         chk("t1_data", {16'd0, bus.data}, {16'd0, t1[k]});
         chk("t1_idx",  {27'd0, bus.idx}, k);
         chk("t1_last", {31'd0, bus.last}, (k == 3) ? 32'd1 : 32'd0);
      end
      tick();
      chk("t1_busy_end", {31'd0, bus.busy}, 32'd0);
      chk("t1_dv_end",   {31'd0, bus.dvalid}, 32'd0);
      chk("t1_err",      {29'd0, bus.err}, 32'd0);

      // size decode table, legal entries run a full block
      for (int t = 0; t < 8; t++) begin
         arm(tbl[t].size);
         chk("tbl_err",  {29'd0, bus.err},  {29'd0, tbl[t].exp_err});
         chk("tbl_busy", {31'd0, bus.busy}, {31'd0, tbl[t].exp_busy});
         if (tbl[t].n != 0) run_block(tbl[t].n, 1'b1, 1'b0);
      end

      // 32-point block with gaps, then random sizes with occasional truncated words
      arm(3'd3);
      run_block(32, 1'b1, 1'b0);
      for (int r = 0; r < 6; r++) begin
         s = $urandom_range(0, 3);
         arm(3'(s));
         chk("rnd_arm_err", {29'd0, bus.err}, 32'd0);
         run_block(4 << s, 1'b1, 1'b1);
      end

      // stall across two completions: overrun drops the second word
      arm(3'd0);
      got.delete();
      bus.dready = 1'b0;
      send_bits(16'hA5A5, 15, 0);
      send_bits(16'h5A5A, 15, 0);
      chk("t3_dv",   {31'd0, bus.dvalid}, 32'd1);
      chk("t3_data", {16'd0, bus.data}, 32'hA5A5);
      chk("t3_idx",  {27'd0, bus.idx}, 32'd0);
      chk("t3_err",  {29'd0, bus.err}, 32'd2);
      bus.dready = 1'b1;
      tick();
      chk("t3_dv_off", {31'd0, bus.dvalid}, 32'd0);
      send_bits(16'hC3C3, 15, 0);
      chk("t3_next_data", {16'd0, bus.data}, 32'hC3C3);
      chk("t3_next_idx",  {27'd0, bus.idx}, 32'd1);
      send_bits(16'h0F0F, 15, 0);
      send_bits(16'hF0F0, 15, 0);
      chk("t3_last", {31'd0, bus.last}, 32'd1);
      tick(); tick();
      chk("t3_busy", {31'd0, bus.busy}, 32'd0);
      chk("t3_cnt",  got.size(), 32'd4);

      // framing error after 7 bits of word 2
      arm(3'd0);
      send_bits(16'h1111, 15, 0);
      send_bits(16'h2222, 15, 0);
      send_bits(16'h3333, 15, 9);
      tick();
      chk("t4_err", {29'd0, bus.err}, 32'd1);
      chk("t4_dv",  {31'd0, bus.dvalid}, 32'd0);
      send_bits(16'h4444, 15, 0);
      chk("t4_data", {16'd0, bus.data}, 32'h4444);
      chk("t4_idx",  {27'd0, bus.idx}, 32'd2);
      send_bits(16'h5555, 15, 0);
      chk("t4_last", {31'd0, bus.last}, 32'd1);
      tick(); tick();
      chk("t4_busy", {31'd0, bus.busy}, 32'd0);

      // reset in the middle of word 3
      arm(3'd0);
      send_bits(16'hAAAA, 15, 0);
      send_bits(16'hBBBB, 15, 0);
      send_bits(16'hCCCC, 15, 0);
      send_bits(16'hDDDD, 15, 7);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out", {5'd0, bus.data, bus.idx, bus.last, bus.dvalid, bus.busy, bus.err}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      got.delete();
      send_bits(16'hEEEE, 15, 0);
      tick();
      chk("t6_idle_dv",   {31'd0, bus.dvalid}, 32'd0);
      chk("t6_idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("t6_idle_cnt",  got.size(), 32'd0);
      arm(3'd0);
      run_block(4, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
